// File: rtl/fetch_unit_pf_if.sv
// Fetch unit bus bundle: instruction-memory read port plus decode-side valid/ready handshake.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_pf_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_unit_pf.sv
// Prefetching instruction fetch unit: 1-cycle imem, DEPTH-entry {pc, instr} buffer, branch flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_unit_pf #(
    parameter int              ADDR_W   = 10,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_addr,
    fetch_unit_pf_if.master   bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    logic               pop_req;
    logic               pop;
    logic               fill;
    logic               issue;
    logic [CNT_W:0]     occupancy;

    assign bus.out_valid = (count != '0);
    assign pop_req       = bus.out_valid & bus.out_ready;
    assign pop           = pop_req & ~branch;
    assign fill          = inflight & ~branch;

    // Slots already committed after this cycle's pop; a new request needs one more free.
    assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop_req);
    assign issue     = ~reset & en & ~branch & (occupancy < (CNT_W+1)'(DEPTH));

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.out_instr = instr_mem[rd_ptr];
    assign bus.out_pc    = pc_mem[rd_ptr];

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (branch) begin
            pc       <= branch_addr;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                pc     <= pc + 1'b1;
                req_pc <= pc;
            end
            inflight <= issue;
            if (fill) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(fill) - CNT_W'(pop);
        end
    end

    // NOTE: the buffer storage is reset so the head fields read zero out of reset; it is only DEPTH entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_mem <= '{default: '0};
            pc_mem    <= '{default: '0};
        end else if (fill) begin
            instr_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]    <= req_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (en && !bus.out_valid && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (branch && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit_pf.sv
// Self-checking bench for fetch_unit_pf: vector table, directed corner sequences,
// and random traffic against a queue-based model of the fetch stream.
module tb_fetch_unit_pf;
    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              branch;
    logic [ADDR_W-1:0] branch_addr;

    fetch_unit_pf_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_unit_pf #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC('0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .branch(branch),
        .branch_addr(branch_addr),
        .bus(bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [ADDR_W-1:0] a);
        return 32'h100 + 32'(a);
    endfunction

    // Synchronous instruction memory, 1-cycle latency.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= instr_of(bus.imem_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: delivered-stream view of the fetch unit.
    logic [ADDR_W-1:0] m_q [$];
    bit                m_pend;
    logic [ADDR_W-1:0] m_pend_pc;
    logic [ADDR_W-1:0] m_pc;

    task automatic model_reset();
        m_q.delete();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_pc      = '0;
    endtask

    // Values sampled mid-cycle by the last call to cycle().
    logic              s_req;
    logic [ADDR_W-1:0] s_addr;
    logic              s_valid;
    logic [ADDR_W-1:0] s_pc;
    logic [INSTR_W-1:0] s_instr;

    // Called at posedge+1: drive inputs, sample and compare with the model, advance one clock.
    task automatic cycle(input bit e, input bit r, input bit b, input logic [ADDR_W-1:0] ba);
        bit exp_valid;
        bit exp_req;
        bit pop;
        en = e;
        bus.out_ready = r;
        branch = b;
        branch_addr = ba;
        #3;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.out_valid;
        s_pc    = bus.out_pc;
        s_instr = bus.out_instr;
        exp_valid = (m_q.size() != 0);
        pop       = exp_valid && r;
        exp_req   = e && !b && ((int'(m_q.size()) + int'(m_pend) - int'(pop)) < DEPTH);
        check("model_imem_req", 32'(s_req), 32'(exp_req));
        check("model_imem_addr", 32'(s_addr), 32'(m_pc));
        check("model_out_valid", 32'(s_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("model_out_pc", 32'(s_pc), 32'(m_q[0]));
            check("model_out_instr", s_instr, instr_of(m_q[0]));
        end
        @(posedge clk);
        #1;
        if (b) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc   = ba;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            m_pend = exp_req;
            if (exp_req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        branch = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit                en;
        bit                ready;
        bit                br;
        logic [ADDR_W-1:0] baddr;
        bit                exp_req;
        logic [ADDR_W-1:0] exp_addr;
        bit                exp_valid;
        logic [ADDR_W-1:0] exp_pc;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs = '{
            '{1, 1, 0, 0, 1,  0, 0, 0},
            '{1, 1, 0, 0, 1,  1, 0, 0},
            '{1, 1, 0, 0, 1,  2, 1, 0},
            '{1, 1, 0, 0, 1,  3, 1, 1},
            '{1, 1, 0, 0, 1,  4, 1, 2},
            '{1, 1, 0, 0, 1,  5, 1, 3},
            '{1, 1, 0, 0, 1,  6, 1, 4},
            '{1, 1, 0, 0, 1,  7, 1, 5},
            '{1, 0, 0, 0, 1,  8, 1, 6},
            '{1, 0, 0, 0, 1,  9, 1, 6},
            '{0, 1, 0, 0, 0, 10, 1, 6},
            '{0, 1, 0, 0, 0, 10, 1, 7}
        };

        reset = 1'b1;
        en = 1'b1;
        branch = 1'b0;
        branch_addr = '0;
        bus.out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_imem_req", 32'(bus.imem_req), 0);
        check("rst_imem_addr", 32'(bus.imem_addr), 0);
        check("rst_out_pc", 32'(bus.out_pc), 0);
        check("rst_out_instr", bus.out_instr, 0);
        reset = 1'b0;

        // Streaming, backpressure and enable-drop vectors from reset release.
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].en, vecs[i].ready, vecs[i].br, vecs[i].baddr);
            check("vec_imem_req", 32'(s_req), 32'(vecs[i].exp_req));
            check("vec_imem_addr", 32'(s_addr), 32'(vecs[i].exp_addr));
            check("vec_out_valid", 32'(s_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check("vec_out_pc", 32'(s_pc), 32'(vecs[i].exp_pc));
                check("vec_out_instr", s_instr, instr_of(vecs[i].exp_pc));
            end
        end

        // Full buffer under out_ready=0, then lossless drain.
        do_reset();
        repeat (8) cycle(1, 0, 0, '0);
        check("full_valid", 32'(s_valid), 1);
        check("full_head_pc", 32'(s_pc), 0);
        check("full_req_stopped", 32'(s_req), 0);
        check("full_pc_held", 32'(s_addr), 4);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, '0);
            check("drain_valid", 32'(s_valid), 1);
            check("drain_pc", 32'(s_pc), 32'(i));
        end

        // Branch with 3 buffered entries and one response in flight.
        do_reset();
        repeat (4) cycle(1, 0, 0, '0);
        cycle(1, 1, 1, 10'h2A0);
        check("br_no_req", 32'(s_req), 0);
        cycle(1, 1, 0, '0);
        check("br_b1_valid", 32'(s_valid), 0);
        check("br_b1_addr", 32'(s_addr), 32'h2A0);
        check("br_b1_req", 32'(s_req), 1);
        cycle(1, 1, 0, '0);
        check("br_b2_valid", 32'(s_valid), 0);
        cycle(1, 1, 0, '0);
        check("br_b3_valid", 32'(s_valid), 1);
        check("br_b3_pc", 32'(s_pc), 32'h2A0);
        cycle(1, 1, 0, '0);
        check("br_b4_pc", 32'(s_pc), 32'h2A1);

        // PC wrap at the top of the address space.
        cycle(1, 1, 1, 10'h3FE);
        repeat (2) cycle(1, 1, 0, '0);
        for (int i = 0; i < 4; i++) begin
            logic [ADDR_W-1:0] want;
            want = 10'h3FE + 10'(i);
            cycle(1, 1, 0, '0);
            check("wrap_pc", 32'(s_pc), 32'(want));
        end

        // en low for 5 cycles mid-stream.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(!(i >= 6 && i <= 10), 1, 0, '0);
            case (i)
                6:  begin check("en_off_req", 32'(s_req), 0); check("en_off_pc4", 32'(s_pc), 4); end
                7:  begin check("en_off_last_valid", 32'(s_valid), 1); check("en_off_pc5", 32'(s_pc), 5); end
                8:  check("en_off_empty", 32'(s_valid), 0);
                10: begin check("en_off_empty2", 32'(s_valid), 0); check("en_off_pc_held", 32'(s_addr), 6); end
                11: begin check("en_on_req", 32'(s_req), 1); check("en_on_addr", 32'(s_addr), 6); end
                13: begin check("en_on_valid", 32'(s_valid), 1); check("en_on_pc", 32'(s_pc), 6); end
                default: ;
            endcase
        end

        // Async reset mid-cycle with a full buffer and a request being issued.
        do_reset();
        repeat (6) cycle(1, 0, 0, '0);
        en = 1'b1;
        bus.out_ready = 1'b1;
        #2;
        check("prerst_valid", 32'(bus.out_valid), 1);
        check("prerst_req", 32'(bus.imem_req), 1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 0);
        check("async_rst_req", 32'(bus.imem_req), 0);
        check("async_rst_addr", 32'(bus.imem_addr), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle(1, 1, 0, '0);
        check("restart_req", 32'(s_req), 1);
        check("restart_addr", 32'(s_addr), 0);
        cycle(1, 1, 0, '0);
        cycle(1, 1, 0, '0);
        check("restart_pc", 32'(s_pc), 0);

        // Random traffic checked against the model every cycle.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 19) == 0, ADDR_W'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit_pf.md
Name: fetch_unit_pf

Overview:
Parametrised prefetching instruction fetch unit. It is the successor to the basic PC-plus-imem fetch path.
- Drives a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, each with its PC, in a DEPTH-entry FIFO.
- Presents them to decode over a valid/ready handshake.
- Handles branch redirect by flushing the buffer and discarding in-flight data.
- Sits between the program counter/branch logic and the decode stage.

Parameters:
ADDR_W, 10, instruction word-address width (PC width)
INSTR_W, 32, instruction width
DEPTH, 4, prefetch buffer entries; power of two, >= 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  fetch enable; 0 stops new memory requests (buffer still drains)
branch  in  1  redirect request, single-cycle pulse
branch_addr  in  ADDR_W  redirect target word address
imem_req  out  1  memory read request this cycle
imem_addr  out  ADDR_W  memory read address (current PC register)
imem_rdata  in  INSTR_W  read data, valid in the cycle after imem_req
out_valid  out  1  buffer head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  PC of head instruction

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, buffer empty (count=0, rd/wr pointers 0), inflight=0.
  - out_valid=0, imem_req=0, out_instr/out_pc=0.
  - Reset mid-operation drops all buffered and in-flight data immediately.
- Memory protocol:
  - imem_addr=pc at all times.
  - imem_rdata is sampled in the cycle after a request (inflight=1); its PC is tracked in a register.
- Issue rule:
  - imem_req = en & ~branch & (count + inflight - pop < DEPTH), where pop = out_valid & out_ready.
  - On issue: pc <= pc+1, modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0); inflight <= 1.
  - Otherwise pc holds and inflight <= 0.
- Fill: when inflight=1 and no branch, {pc_of_req, imem_rdata} is written at wr_ptr at that edge. It is visible as head no earlier than the next cycle.
- Drain:
  - out_valid = (count != 0).
  - Head fields come from registered storage at rd_ptr.
  - pop advances rd_ptr; a simultaneous fill and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: request in cycle t -> buffered at end of t+1 -> out_valid in t+2 if buffer was empty. Steady state with out_ready=1 is one instruction per cycle.
- Full: count never exceeds DEPTH. The issue rule guarantees every in-flight response has a slot, so there is no overflow path.
- Empty: out_valid=0; out_instr/out_pc hold last values (don't care).
- Branch (cycle b):
  - pc <= branch_addr; imem_req=0 in cycle b.
  - Buffer is flushed (count <= 0, pointers reset); a pop in cycle b is ignored.
  - Any response arriving in cycle b is discarded; inflight <= 0.
  - First request in b+1 (if en); out_pc=branch_addr valid in b+3.
  - Branch overrides en=0: PC is still redirected.
- en=0: no requests issue. The response to a request issued the cycle before en fell is still buffered. Buffered entries still drain.
- Simultaneous branch and reset: reset wins.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds outputs perf_stall_cnt (32 bits), counting cycles with out_valid=0 and en=1.
  - Adds perf_flush_cnt (32 bits), counting branch pulses.
  - Both are reset to 0 and saturate at 2^32-1.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, en=1, out_ready=1, imem returns addr+0x100 -> imem_addr 0,1,2… each cycle; out_valid first in cycle 2 with out_pc=0, out_instr=0x100; then one per cycle in order.
- out_ready=0 with en=1, DEPTH=4 -> exactly 4 entries (pc 0..3) buffered; imem_req=0 thereafter with pc=4; raising out_ready drains 0,1,2,3,4… with no loss or duplication.
- Branch to 0x2A0 in cycle b while buffer holds 3 entries and a response is in flight -> out_valid=0 in b+1 and b+2; out_pc=0x2A0 in b+3; no stale PCs ever appear.
- pc=0x3FE, ADDR_W=10, continuous fetch -> out_pc sequence 0x3FE, 0x3FF, 0x000, 0x001.
- en dropped for 5 cycles mid-stream -> the one in-flight response is still delivered, then out_valid=0; fetch resumes at the next sequential PC with no gap or repeat.
- Async reset pulse asserted mid-stream with buffer full -> out_valid and imem_req fall immediately (same cycle); after release, fetch restarts at RESET_PC.
